// File: rtl/izh_pkg.sv
// izh_pkg: shared types, fixed-point constants and the N-bit narrowing helper
// for the Izhikevich array core.
// Optional feature macro: IZH_SATURATE_EN selects saturating narrowing
// (undefined: two's-complement wrap).
package izh_pkg;

  // One state per shared-multiplier cycle, plus write-back and completion.
  typedef enum logic [3:0] {
    IDLE,
    M_VV,
    M_KVV,
    M_5V,
    M_BV,
    M_ABW,
    M_DV,
    M_DW,
    WB,
    DONE
  } izh_state_t;

  // Default fixed-point coefficients at six fractional bits.
  localparam int C_K   = 3;          // 0.046875
  localparam int C_5   = 320;        // 5.0
  localparam int C_140 = 140 << 6;   // 140.0

  // Narrow a wide signed value to n bits, returned sign-extended to 64 bits.
  function automatic logic signed [63:0] izh_narrow(input logic signed [63:0] x,
                                                     input int unsigned n);
`ifdef IZH_SATURATE_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
`else
    return (x <<< (64 - n)) >>> (64 - n);
`endif
  endfunction

endpackage

// File: rtl/izh_fx_mul.sv
// izh_fx_mul: signed W x W fixed-point multiply, floor-shifted right by Q.
// Ports: a, b - signed operands; p - product >>> Q, truncated to W bits.
module izh_fx_mul #(
  parameter int unsigned W = 32,
  parameter int unsigned Q = 6
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);

  logic signed [2*W-1:0] full;

  // Sign-extend before multiplying so the low 2W bits are the exact signed product.
  assign full = $signed({{W{a[W-1]}}, a} * {{W{b[W-1]}}, b});
  assign p    = W'(full >>> Q);

endmodule

// File: rtl/izhikevich_array_core.sv
// izhikevich_array_core: time-multiplexed Izhikevich neuron array. A single
// shared multiplier, sequenced by an FSM, performs one Euler step of v and w
// for every neuron per accepted start pulse.
// Ports: clk, reset (sync, active-high); start/step launch a step; i_we/i_addr/
// i_data write the per-neuron input current (only while idle); rd_addr selects
// the combinational rd_v/rd_w readback; busy, done (one-cycle pulse) and
// spikes (per-neuron flags of the last step) report status.
// Optional feature macro: IZH_SATURATE_EN (saturating narrowing of v and w).
module izhikevich_array_core
  import izh_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter int unsigned Q       = 6,
  parameter int unsigned NEURONS = 4,
  parameter int unsigned ACC_W   = 2 * N,
  parameter int          A       = 1,
  parameter int          B       = 13,
  parameter int          C       = -4160,
  parameter int          D       = 512,
  parameter int          V_PEAK  = 1920,
  localparam int unsigned AW     = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N-1:0]       step,
  input  logic               i_we,
  input  logic [AW-1:0]      i_addr,
  input  logic [N-1:0]       i_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [N-1:0]       rd_v,
  output logic [N-1:0]       rd_w,
  output logic               busy,
  output logic               done,
  output logic [NEURONS-1:0] spikes
);

  localparam logic signed [N-1:0] V_RST    = N'(C);
  localparam logic signed [N-1:0] W_RST    = N'((B * C) >>> Q);
  localparam logic signed [N-1:0] V_PEAK_N = N'(V_PEAK);
  localparam logic [AW-1:0]       K_LAST   = AW'(NEURONS - 1);

  izh_state_t state, next_state;
  logic [AW-1:0] k;
  logic signed [N-1:0] step_r;
  logic signed [N-1:0] v_mem [NEURONS];
  logic signed [N-1:0] w_mem [NEURONS];
  logic signed [N-1:0] i_mem [NEURONS];
  logic signed [ACC_W-1:0] vv_r, kvv_r, v5_r, bv_r, dw_r, dvs_r, dws_r;

  logic signed [ACC_W-1:0] v_x, w_x, i_x, step_x, dv_c;
  logic signed [ACC_W-1:0] mul_a, mul_b, mul_p;
  logic signed [N-1:0] v_new, w_new, w_spk;
  logic spike_c;

  assign rd_v = v_mem[rd_addr];
  assign rd_w = w_mem[rd_addr];

  // Old state of the neuron being processed, widened to the datapath.
  assign v_x    = ACC_W'(v_mem[k]);
  assign w_x    = ACC_W'(w_mem[k]);
  assign i_x    = ACC_W'(i_mem[k]);
  assign step_x = ACC_W'(step_r);
  assign dv_c   = kvv_r + v5_r + ACC_W'(C_140) - w_x + i_x;

  izh_fx_mul #(.W(ACC_W), .Q(Q)) u_mul (.a(mul_a), .b(mul_b), .p(mul_p));

  // Next-state logic: one multiplier state per cycle, then write-back.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = M_VV;
      M_VV:    next_state = M_KVV;
      M_KVV:   next_state = M_5V;
      M_5V:    next_state = M_BV;
      M_BV:    next_state = M_ABW;
      M_ABW:   next_state = M_DV;
      M_DV:    next_state = M_DW;
      M_DW:    next_state = WB;
      WB:      next_state = (k == K_LAST) ? DONE : M_VV;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shared multiplier operand selection.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state)
      M_VV:    begin mul_a = v_x;            mul_b = v_x;         end
      M_KVV:   begin mul_a = ACC_W'(C_K);    mul_b = vv_r;        end
      M_5V:    begin mul_a = ACC_W'(C_5);    mul_b = v_x;         end
      M_BV:    begin mul_a = ACC_W'(B);      mul_b = v_x;         end
      M_ABW:   begin mul_a = ACC_W'(A);      mul_b = bv_r - w_x;  end
      M_DV:    begin mul_a = dvs_sel(dv_c);  mul_b = step_x;      end
      M_DW:    begin mul_a = dw_r;           mul_b = step_x;      end
      default: begin mul_a = '0;             mul_b = '0;          end
    endcase
  end

  function automatic logic signed [ACC_W-1:0] dvs_sel(input logic signed [ACC_W-1:0] x);
    return x;
  endfunction

  // Write-back values; the spike compare sees the narrowed v.
  always_comb begin
    v_new   = N'(izh_narrow(64'(v_x + dvs_r), N));
    w_new   = N'(izh_narrow(64'(w_x + dws_r), N));
    w_spk   = N'(izh_narrow(64'(ACC_W'(w_new) + ACC_W'(D)), N));
    spike_c = (v_new >= V_PEAK_N);
  end

  // State, datapath and storage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      spikes <= '0;
      step_r <= '0;
      vv_r   <= '0;
      kvv_r  <= '0;
      v5_r   <= '0;
      bv_r   <= '0;
      dw_r   <= '0;
      dvs_r  <= '0;
      dws_r  <= '0;
      for (int i = 0; i < int'(NEURONS); i++) begin
        v_mem[i] <= V_RST;
        w_mem[i] <= W_RST;
        i_mem[i] <= '0;
      end
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (next_state == DONE);
      if (i_we && !busy) i_mem[i_addr] <= i_data;
      unique case (state)
        IDLE: if (start) begin
          step_r <= step;
          spikes <= '0;
          k      <= '0;
        end
        M_VV:  vv_r  <= mul_p;
        M_KVV: kvv_r <= mul_p;
        M_5V:  v5_r  <= mul_p;
        M_BV:  bv_r  <= mul_p;
        M_ABW: dw_r  <= mul_p;
        M_DV:  dvs_r <= mul_p;
        M_DW:  dws_r <= mul_p;
        WB: begin
          if (spike_c) begin
            v_mem[k]  <= V_RST;
            w_mem[k]  <= w_spk;
            spikes[k] <= 1'b1;
          end else begin
            v_mem[k] <= v_new;
            w_mem[k] <= w_new;
          end
          if (k != K_LAST) k <= k + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_izhikevich_array_core.sv
// Self-checking bench for izhikevich_array_core (default parameters).
module tb_izhikevich_array_core;

  localparam int NN = 4;

  logic        clk = 1'b0;
  logic        reset, start, i_we;
  logic [15:0] step, i_data;
  logic [1:0]  i_addr, rd_addr;
  logic [15:0] rd_v, rd_w;
  logic        busy, done;
  logic [3:0]  spikes;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  izhikevich_array_core dut (
    .clk(clk), .reset(reset), .start(start), .step(step),
    .i_we(i_we), .i_addr(i_addr), .i_data(i_data), .rd_addr(rd_addr),
    .rd_v(rd_v), .rd_w(rd_w), .busy(busy), .done(done), .spikes(spikes)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model (real-valued rules in Q6 integers) ----
  longint mv[NN], mw[NN], mi[NN];
  logic [3:0] mspk;

  function automatic longint acc(input longint x);
    return longint'(int'(x));
  endfunction

  function automatic longint fmul(input longint x, input longint y);
    return acc((x * y) >>> 6);
  endfunction

  function automatic longint narrow16(input longint x);
`ifdef IZH_SATURATE_EN
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
`else
    return longint'(shortint'(x));
`endif
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NN; n++) begin
      mv[n] = -4160;
      mw[n] = longint'(13 * -4160) >>> 6;
      mi[n] = 0;
    end
    mspk = '0;
  endtask

  task automatic model_step(input longint st);
    longint dv, dw, vn, wn;
    mspk = '0;
    for (int n = 0; n < NN; n++) begin
      dv = acc(fmul(3, fmul(mv[n], mv[n])) + fmul(320, mv[n]) + 8960 - mw[n] + mi[n]);
      dw = fmul(1, acc(fmul(13, mv[n]) - mw[n]));
      vn = narrow16(mv[n] + fmul(dv, st));
      wn = narrow16(mw[n] + fmul(dw, st));
      if (vn >= 1920) begin
        mv[n] = -4160;
        mw[n] = narrow16(wn + 512);
        mspk[n] = 1'b1;
      end else begin
        mv[n] = vn;
        mw[n] = wn;
      end
    end
  endtask

  // ---------------- DUT drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; i_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write_i(input int n, input longint val);
    @(negedge clk);
    i_we = 1'b1; i_addr = 2'(n); i_data = 16'(val);
    @(negedge clk);
    i_we = 1'b0;
    mi[n] = longint'(shortint'(val));
  endtask

  task automatic run_step(input string tag, input int st);
    int cnt;
    bit seen;
    @(negedge clk);
    step = 16'(st); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) chk($sformatf("%s busy_on", tag), busy, 1);
      if (done) seen = 1'b1;
    end
    chk($sformatf("%s done_latency", tag), seen ? cnt : -1, 32);
    @(posedge clk); #1;
    chk($sformatf("%s idle_after_done", tag), {busy, done}, 0);
    model_step(st);
  endtask

  task automatic compare_all(input string tag);
    for (int n = 0; n < NN; n++) begin
      rd_addr = 2'(n); #1;
      chk($sformatf("%s v[%0d]", tag, n), $signed(rd_v), mv[n]);
      chk($sformatf("%s w[%0d]", tag, n), $signed(rd_w), mw[n]);
    end
    chk($sformatf("%s spikes", tag), spikes, mspk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [3:0][15:0] iv;
    logic [15:0]      st;
    logic [3:0]       spk;
    logic [3:0][15:0] v;
    logic [3:0][15:0] w;
  } vec_t;

  function automatic vec_t mk(input int i0, input int i1, input int i2, input int i3,
                              input int st, input logic [3:0] spk,
                              input int v0, input int v1, input int v2, input int v3,
                              input int w0, input int w1, input int w2, input int w3);
    vec_t r;
    r.iv[0] = 16'(i0); r.iv[1] = 16'(i1); r.iv[2] = 16'(i2); r.iv[3] = 16'(i3);
    r.st = 16'(st); r.spk = spk;
    r.v[0] = 16'(v0); r.v[1] = 16'(v1); r.v[2] = 16'(v2); r.v[3] = 16'(v3);
    r.w[0] = 16'(w0); r.w[1] = 16'(w1); r.w[2] = 16'(w2); r.w[3] = 16'(w3);
    return r;
  endfunction

  vec_t vecs[6];

  initial begin
    int d1, d2, cnt, dones;

    vecs[0] = mk(0, 0, 0, 0, 64, 4'b0000, -2480, -2480, -2480, -2480, -845, -845, -845, -845);
    vecs[1] = mk(0, 0, 19200, 0, 64, 4'b0100, -2480, -2480, -4160, -2480, -845, -845, -333, -845);
    vecs[2] = mk(0, 0, 0, 0, 0, 4'b0000, -4160, -4160, -4160, -4160, -845, -845, -845, -845);
`ifdef IZH_SATURATE_EN
    vecs[3] = mk(-32768, 0, 0, 0, 256, 4'b1110, -32768, -4160, -4160, -4160, -845, -333, -333, -333);
`else
    vecs[3] = mk(-32768, 0, 0, 0, 256, 4'b1111, -4160, -4160, -4160, -4160, -333, -333, -333, -333);
`endif
    vecs[4] = mk(0, 640, 0, 0, 64, 4'b0000, -2480, -1840, -2480, -2480, -845, -845, -845, -845);
    // v' lands exactly on V_PEAK for neuron 3 and one LSB below for neuron 0.
    vecs[5] = mk(4399, 0, 0, 4400, 64, 4'b1000, 1919, -2480, -2480, -4160, -845, -845, -845, -333);

    reset = 1'b1; start = 1'b0; i_we = 1'b0; step = '0;
    i_addr = '0; i_data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Reset state.
    #1;
    for (int n = 0; n < NN; n++) begin
      rd_addr = 2'(n); #1;
      chk($sformatf("reset v[%0d]", n), $signed(rd_v), -4160);
      chk($sformatf("reset w[%0d]", n), $signed(rd_w), -845);
    end
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset spikes", spikes, 0);

    // Table-driven single steps from reset.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int n = 0; n < NN; n++) write_i(n, longint'($signed(vecs[t].iv[n])));
      run_step($sformatf("vec%0d", t), int'($signed(vecs[t].st)));
      for (int n = 0; n < NN; n++) begin
        rd_addr = 2'(n); #1;
        chk($sformatf("vec%0d v[%0d]", t, n), $signed(rd_v), longint'($signed(vecs[t].v[n])));
        chk($sformatf("vec%0d w[%0d]", t, n), $signed(rd_w), longint'($signed(vecs[t].w[n])));
      end
      chk($sformatf("vec%0d spikes", t), spikes, vecs[t].spk);
    end

    // Back-to-back: start held high re-triggers with an 8*NEURONS+2 period.
    do_reset();
    write_i(2, 19200);
    @(negedge clk);
    step = 16'd64; start = 1'b1;
    cnt = 0; d1 = -1; d2 = -1;
    while (d2 < 0 && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
      if (done) begin
        if (d1 < 0) d1 = cnt;
        else d2 = cnt;
      end
    end
    start = 1'b0;
    chk("b2b first_done", d1, 33);
    chk("b2b period", (d2 < 0) ? -1 : d2 - d1, 34);
    @(posedge clk); #1;
    chk("b2b idle", busy, 0);
    model_step(64);
    model_step(64);
    compare_all("b2b");

    // start and i_we while busy are ignored, including during the done cycle.
    do_reset();
    write_i(1, 3000);
    @(negedge clk);
    step = 16'd64; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
      start = (c >= 5 && c <= 7);
      i_we  = (c >= 10 && c <= 11) || (c == 32);
      i_addr = 2'd1; i_data = 16'd20000;
    end
    start = 1'b0; i_we = 1'b0;
    chk("busy_ignore done_count", dones, 1);
    model_step(64);
    compare_all("busy_ignore step1");
    run_step("busy_ignore2", 64);
    compare_all("busy_ignore step2");

    // Reset in the middle of a step.
    do_reset();
    write_i(0, 5000);
    @(negedge clk);
    step = 16'd64; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    compare_all("midreset");
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("midreset no_done", dones, 0);
    run_step("after_reset", 64);
    compare_all("after_reset");

    // Randomised currents and step sizes against the reference model.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < NN; n++) write_i(n, longint'($urandom_range(0, 28000)) - 4000);
      for (int s = 0; s < 2; s++) begin
        int st;
        st = int'($urandom_range(8, 96));
        run_step($sformatf("rand%0d_%0d", r, s), st);
        compare_all($sformatf("rand%0d_%0d", r, s));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
